// File: rtl/s_fix_multi.sv
// s_fix_multi: per-channel sync polarity normaliser with hysteresis,
// lock indication and stall timeout; emits every sync active-high.
module s_fix_multi #(
  parameter int CHANNELS = 2,
  parameter int CNT_W    = 16,
  parameter int LOCK_N   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] sync_in,
  output logic [CHANNELS-1:0] sync_out,
  output logic [CHANNELS-1:0] pol,
  output logic [CHANNELS-1:0] locked,
  output logic [CHANNELS-1:0] stalled
);

  localparam int AW = $clog2(LOCK_N + 1);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [AW-1:0] LN = AW'(LOCK_N);

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic             s1, s2;
    logic [CNT_W-1:0] cnt, hi_len, lo_len;
    logic             hi_valid, lo_valid, pend;
    logic [AW-1:0]    agree, disagree;
    logic             pol_r, lock_r, stall_r, out_r;

    logic             rise, fall, edg, stall_set;
    logic             cand, agrees;
    logic [AW-1:0]    agree_n, disagree_n;
    logic             pol_n, stall_n;

    always_comb begin
      rise       = ~s2 & s1;
      fall       = s2 & ~s1;
      edg        = rise | fall;
      stall_set  = ~edg & (cnt == CMAX - 1'b1);
      cand       = hi_len > lo_len;
      agrees     = (hi_len == lo_len) | (cand == pol_r);
      agree_n    = agree;
      disagree_n = disagree;
      pol_n      = pol_r;
      if (pend & hi_valid & lo_valid) begin
        if (agrees) begin
          agree_n    = (agree == LN) ? LN : agree + 1'b1;
          disagree_n = '0;
        end else if (disagree == LN - 1'b1) begin
          pol_n      = cand;
          agree_n    = '0;
          disagree_n = '0;
        end else begin
          agree_n    = '0;
          disagree_n = disagree + 1'b1;
        end
      end
      stall_n = stall_r;
      if (edg) begin
        stall_n = 1'b0;
      end else if (stall_set) begin
        stall_n = 1'b1;
      end
      // Losing the input invalidates any confidence built so far
      if (stall_set) begin
        agree_n    = '0;
        disagree_n = '0;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        s1       <= 1'b0;
        s2       <= 1'b0;
        cnt      <= '0;
        hi_len   <= '0;
        lo_len   <= '0;
        hi_valid <= 1'b0;
        lo_valid <= 1'b0;
        pend     <= 1'b0;
        agree    <= '0;
        disagree <= '0;
        pol_r    <= 1'b0;
        lock_r   <= 1'b0;
        stall_r  <= 1'b0;
        out_r    <= 1'b0;
      end else begin
        s1   <= sync_in[g];
        s2   <= s1;
        pend <= edg;
        if (edg) begin
          cnt <= '0;
        end else if (cnt != CMAX) begin
          cnt <= cnt + 1'b1;
        end
        if (fall) begin
          hi_len   <= cnt;
          hi_valid <= (cnt != CMAX);
        end else if (stall_set) begin
          hi_valid <= 1'b0;
        end
        if (rise) begin
          lo_len   <= cnt;
          lo_valid <= (cnt != CMAX);
        end else if (stall_set) begin
          lo_valid <= 1'b0;
        end
        agree    <= agree_n;
        disagree <= disagree_n;
        pol_r    <= pol_n;
        stall_r  <= stall_n;
        lock_r   <= (agree_n == LN) & ~stall_n;
        out_r    <= s2 ^ pol_r;
      end
    end

    assign sync_out[g] = out_r;
    assign pol[g]      = pol_r;
    assign locked[g]   = lock_r;
    assign stalled[g]  = stall_r;
  end

endmodule
